// File: rtl/stage_shell_v2_if.sv
// PHV handshake bundle between an RMT stage shell and its neighbours.
// Ports: phv_in/phv_in_valid/stage_ready_out upstream, phv_out/phv_out_valid/stage_ready_in downstream.
interface stage_shell_v2_if #(
    parameter int PHV_LEN = 1024
) ();
    logic [PHV_LEN-1:0] phv_in;
    logic               phv_in_valid;
    logic               stage_ready_out;
    logic [PHV_LEN-1:0] phv_out;
    logic               phv_out_valid;
    logic               stage_ready_in;

    // driver of the stage (upstream source and downstream sink)
    modport master (
        output phv_in, phv_in_valid, stage_ready_in,
        input  stage_ready_out, phv_out, phv_out_valid
    );

    // the stage shell itself
    modport slave (
        input  phv_in, phv_in_valid, stage_ready_in,
        output stage_ready_out, phv_out, phv_out_valid
    );
endinterface

// File: rtl/stage_shell_v2.sv
// Stage shell: fixed-latency PHV slot (or single-register bypass) into a FWFT FIFO with credits,
// plus a 1-cycle control AXIS forwarder whose headers set bypass mode and clear the PHV counter.
// Ports: clk, rst (sync, active high), phv (slave handshake bundle), c_s_axis_* in, c_m_axis_* out,
// bypass_mode (current mode), phv_count (PHVs popped since reset or clear).
module stage_shell_v2 #(
    parameter int C_S_AXIS_DATA_WIDTH  = 512,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int STAGE_ID             = 0,
    parameter int PHV_LEN              = 1024,
    parameter int LATENCY              = 4,
    parameter int FIFO_DEPTH           = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    stage_shell_v2_if.slave                   phv,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    c_s_axis_tdata,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_s_axis_tuser,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_s_axis_tkeep,
    input  logic                              c_s_axis_tvalid,
    input  logic                              c_s_axis_tlast,
    output logic [C_S_AXIS_DATA_WIDTH-1:0]    c_m_axis_tdata,
    output logic [C_S_AXIS_TUSER_WIDTH-1:0]   c_m_axis_tuser,
    output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  c_m_axis_tkeep,
    output logic                              c_m_axis_tvalid,
    output logic                              c_m_axis_tlast,
    output logic                              bypass_mode,
    output logic [31:0]                       phv_count
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + LATENCY + 2) + 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_IN_PKT = 1'b1;

    logic [0:0]                        state_q, state_d;
    logic [C_S_AXIS_DATA_WIDTH-1:0]    tdata_q;
    logic [C_S_AXIS_TUSER_WIDTH-1:0]   tuser_q;
    logic [C_S_AXIS_DATA_WIDTH/8-1:0]  tkeep_q;
    logic                              tvalid_q, tlast_q;
    logic                              pend_q, pend_d;
    logic                              mode_q, mode_d;
    logic [31:0]                       cnt_q, cnt_d;
    logic [LATENCY-1:0]                svld_q, svld_d;
    logic                              bvld_q, bvld_d;
    logic [CW:0]                       fcnt_q, fcnt_d;
    logic [CW-1:0]                     wptr_q, wptr_d;
    logic [CW-1:0]                     rptr_q, rptr_d;

    logic [PHV_LEN-1:0] sdata_q [LATENCY];
    logic [PHV_LEN-1:0] bdata_q;
    logic [PHV_LEN-1:0] mem_q [FIFO_DEPTH];
    logic [PHV_LEN-1:0] push_data;

    logic [OW-1:0] occ;
    logic          ready, accept, push, pop, out_vld, hdr;

    // Credits count in-flight PHVs too, so the FIFO can never overflow.
    // A pending mode change blocks intake until the pipeline has drained.
    always_comb begin
        occ = OW'(fcnt_q) + OW'(bvld_q);
        for (int i = 0; i < LATENCY; i++) begin
            occ = occ + OW'(svld_q[i]);
        end
        ready   = ~rst & (occ < OW'(FIFO_DEPTH)) & (pend_q == mode_q);
        accept  = phv.phv_in_valid & ready;
        // only one source can be valid: the mode flips only when both are empty
        push      = svld_q[LATENCY-1] | bvld_q;
        push_data = bvld_q ? bdata_q : sdata_q[LATENCY-1];
        out_vld   = (fcnt_q != '0) & ~rst;
        pop       = out_vld & phv.stage_ready_in;
    end

    // Config header: first beat of a packet, addressed to this stage, type nibble F.
    always_comb begin
        hdr = c_s_axis_tvalid & (state_q == S_IDLE)
            & (c_s_axis_tdata[15:12] == 4'(STAGE_ID))
            & (c_s_axis_tdata[11:8] == 4'hF);
        state_d = state_q;
        if (c_s_axis_tvalid) begin
            state_d = c_s_axis_tlast ? S_IDLE : S_IN_PKT;
        end
        pend_d = hdr ? c_s_axis_tdata[16] : pend_q;
        mode_d = mode_q;
        if ((svld_q == '0) && !bvld_q && !accept) begin
            mode_d = pend_q;
        end
        cnt_d = cnt_q;
        if (hdr && c_s_axis_tdata[17]) begin
            cnt_d = '0;
        end else if (pop) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_comb begin
        svld_d[0] = accept & ~mode_q;
        for (int i = 1; i < LATENCY; i++) begin
            svld_d[i] = svld_q[i-1];
        end
        bvld_d = accept & mode_q;
        wptr_d = push ? wptr_q + CW'(1) : wptr_q;
        rptr_d = pop ? rptr_q + CW'(1) : rptr_q;
        fcnt_d = fcnt_q;
        if (push && !pop) begin
            fcnt_d = fcnt_q + (CW+1)'(1);
        end else if (!push && pop) begin
            fcnt_d = fcnt_q - (CW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            tdata_q  <= '0;
            tuser_q  <= '0;
            tkeep_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            pend_q   <= 1'b0;
            mode_q   <= 1'b0;
            cnt_q    <= '0;
            svld_q   <= '0;
            bvld_q   <= 1'b0;
            fcnt_q   <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
        end else begin
            state_q  <= state_d;
            tdata_q  <= c_s_axis_tdata;
            tuser_q  <= c_s_axis_tuser;
            tkeep_q  <= c_s_axis_tkeep;
            tvalid_q <= c_s_axis_tvalid;
            tlast_q  <= c_s_axis_tlast;
            pend_q   <= pend_d;
            mode_q   <= mode_d;
            cnt_q    <= cnt_d;
            svld_q   <= svld_d;
            bvld_q   <= bvld_d;
            fcnt_q   <= fcnt_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
        end
    end

    // Payload storage needs no reset; the valid bits and pointers qualify it.
    always_ff @(posedge clk) begin
        sdata_q[0] <= phv.phv_in;
        for (int i = 1; i < LATENCY; i++) begin
            sdata_q[i] <= sdata_q[i-1];
        end
        bdata_q <= phv.phv_in;
        if (push) begin
            mem_q[wptr_q] <= push_data;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fcnt_q == (CW+1)'(FIFO_DEPTH))));

    assign phv.stage_ready_out = ready;
    assign phv.phv_out         = mem_q[rptr_q];
    assign phv.phv_out_valid   = out_vld;

    assign c_m_axis_tdata  = rst ? '0 : tdata_q;
    assign c_m_axis_tuser  = rst ? '0 : tuser_q;
    assign c_m_axis_tkeep  = rst ? '0 : tkeep_q;
    assign c_m_axis_tvalid = tvalid_q & ~rst;
    assign c_m_axis_tlast  = tlast_q & ~rst;

    assign bypass_mode = mode_q;
    assign phv_count   = cnt_q;
endmodule

// File: tb/tb_stage_shell_v2.sv
// Directed bench for stage_shell_v2: control-beat table plus hand sequences
// for latency, backpressure, mode switch, counter wrap/clear and mid-stream reset.
module tb_stage_shell_v2;
    localparam int DW  = 512;
    localparam int UW  = 128;
    localparam int SID = 3;
    localparam int PL  = 64;
    localparam int LAT = 4;
    localparam int FD  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stage_shell_v2_if #(.PHV_LEN(PL)) pif ();

    logic [DW-1:0]   s_tdata, m_tdata, exp_td;
    logic [UW-1:0]   s_tuser, m_tuser, exp_tu;
    logic [DW/8-1:0] s_tkeep, m_tkeep, exp_tk;
    logic            s_tvalid, s_tlast, m_tvalid, m_tlast;
    logic            bypass_mode;
    logic [31:0]     phv_count;

    stage_shell_v2 #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(UW),
        .STAGE_ID            (SID),
        .PHV_LEN             (PL),
        .LATENCY             (LAT),
        .FIFO_DEPTH          (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .phv            (pif),
        .c_s_axis_tdata (s_tdata),
        .c_s_axis_tuser (s_tuser),
        .c_s_axis_tkeep (s_tkeep),
        .c_s_axis_tvalid(s_tvalid),
        .c_s_axis_tlast (s_tlast),
        .c_m_axis_tdata (m_tdata),
        .c_m_axis_tuser (m_tuser),
        .c_m_axis_tkeep (m_tkeep),
        .c_m_axis_tvalid(m_tvalid),
        .c_m_axis_tlast (m_tlast),
        .bypass_mode    (bypass_mode),
        .phv_count      (phv_count)
    );

    typedef struct {
        logic        vld;
        logic        last;
        logic [31:0] data;
        logic        exp_byp;
    } beat_t;

    int n_vec = 0;
    int n_err = 0;
    logic [PL-1:0] got_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] hw(input logic byp, input logic clr,
                                       input logic [3:0] sid, input logic [3:0] typ);
        return {14'h0, clr, byp, sid, typ, 8'h00};
    endfunction

    task automatic drive_beat(input logic v, input logic l, input logic [31:0] d, input int tag);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(tag);
        s_tdata  = {{15{w}}, d};
        s_tuser  = {4{w}};
        s_tkeep  = {2{w}};
        s_tvalid = v;
        s_tlast  = l;
    endtask

    // Single header beat, then idle; returns two negedges later.
    task automatic send_hdr(input logic byp, input logic clr);
        drive_beat(1'b1, 1'b1, hw(byp, clr, 4'(SID), 4'hF), 99);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        @(negedge clk);
    endtask

    // Offer one PHV at a negedge and measure cycles until it shows on phv_out.
    task automatic lat_test(input logic [PL-1:0] d, input int exp_lat, input string nm);
        int  k;
        bit  seen;
        chk({nm, "_ready"}, 64'(pif.stage_ready_out), 64'd1);
        pif.phv_in       = d;
        pif.phv_in_valid = 1'b1;
        @(negedge clk);
        pif.phv_in_valid = 1'b0;
        k    = 1;
        seen = 0;
        while (!seen && k <= 20) begin
            if (pif.phv_out_valid) seen = 1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        chk({nm, "_latency"}, 64'(k), 64'(exp_lat));
        chk({nm, "_data"}, 64'(pif.phv_out), 64'(d));
    endtask

    // Records every pop; sampled after the negedge drivers have settled.
    always @(negedge clk) begin
        #1;
        if (pif.phv_out_valid && pif.stage_ready_in) got_q.push_back(pif.phv_out);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        beat_t tbl [11];
        int    acc;
        int    viol;
        int    waits;

        tbl[0]  = '{1'b1, 1'b1, hw(1'b1, 1'b0, 4'(SID), 4'hF), 1'b1};
        tbl[1]  = '{1'b1, 1'b1, hw(1'b0, 1'b1, 4'(SID + 1), 4'hF), 1'b1};
        tbl[2]  = '{1'b1, 1'b1, hw(1'b0, 1'b0, 4'(SID), 4'hE), 1'b1};
        tbl[3]  = '{1'b1, 1'b0, hw(1'b0, 1'b0, 4'(SID + 1), 4'hF), 1'b1};
        tbl[4]  = '{1'b1, 1'b0, hw(1'b0, 1'b1, 4'(SID), 4'hF), 1'b1};
        tbl[5]  = '{1'b1, 1'b1, hw(1'b0, 1'b0, 4'(SID), 4'hF), 1'b1};
        tbl[6]  = '{1'b0, 1'b1, hw(1'b0, 1'b0, 4'(SID), 4'hF), 1'b1};
        tbl[7]  = '{1'b1, 1'b1, hw(1'b0, 1'b0, 4'(SID), 4'hF), 1'b0};
        tbl[8]  = '{1'b1, 1'b0, hw(1'b1, 1'b0, 4'(SID), 4'hF), 1'b1};
        tbl[9]  = '{1'b1, 1'b1, hw(1'b0, 1'b0, 4'(SID), 4'hF), 1'b1};
        tbl[10] = '{1'b1, 1'b1, hw(1'b0, 1'b0, 4'(SID), 4'hF), 1'b0};

        rst              = 1'b1;
        pif.phv_in       = '0;
        pif.phv_in_valid = 1'b0;
        pif.stage_ready_in = 1'b1;
        drive_beat(1'b1, 1'b1, 32'h0, 0);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid", 64'(pif.phv_out_valid), 64'd0);
        chk("rst_ready", 64'(pif.stage_ready_out), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_m_tdata", 64'(m_tdata[63:0]), 64'd0);
        rst      = 1'b0;
        s_tvalid = 1'b0;
        #1;
        chk("post_rst_ready", 64'(pif.stage_ready_out), 64'd1);
        chk("post_rst_bypass", 64'(bypass_mode), 64'd0);
        chk("post_rst_count", 64'(phv_count), 64'd0);
        @(negedge clk);

        // normal flow
        lat_test(64'hA5A5_A5A5_A5A5_A5A5, LAT + 1, "norm");
        @(negedge clk);
        chk("norm_count", 64'(phv_count), 64'd1);
        chk("norm_drained", 64'(pif.phv_out_valid), 64'd0);

        // backpressure: credits stop intake at FIFO_DEPTH
        pif.stage_ready_in = 1'b0;
        got_q.delete();
        acc = 0;
        for (int c = 0; c < 20; c++) begin
            pif.phv_in       = 64'(acc);
            pif.phv_in_valid = 1'b1;
            if (pif.stage_ready_out) acc++;
            @(negedge clk);
        end
        pif.phv_in_valid = 1'b0;
        chk("bp_accepted", 64'(acc), 64'(FD));
        chk("bp_ready_low", 64'(pif.stage_ready_out), 64'd0);
        repeat (LAT + 2) @(negedge clk);
        chk("bp_fifo_valid", 64'(pif.phv_out_valid), 64'd1);
        pif.stage_ready_in = 1'b1;
        repeat (20) @(negedge clk);
        chk("bp_popped", 64'(got_q.size()), 64'(FD));
        for (int i = 0; i < got_q.size(); i++) begin
            chk($sformatf("bp_tag%0d", i), 64'(got_q[i]), 64'(i));
        end
        chk("bp_count", 64'(phv_count), 64'(FD + 1));

        // control table: forwarding and header decode
        for (int i = 0; i < 11; i++) begin
            drive_beat(tbl[i].vld, tbl[i].last, tbl[i].data, i);
            exp_td = s_tdata;
            exp_tu = s_tuser;
            exp_tk = s_tkeep;
            @(negedge clk);
            chk($sformatf("tbl%0d_tvalid", i), 64'(m_tvalid), 64'(tbl[i].vld));
            chk($sformatf("tbl%0d_tlast", i), 64'(m_tlast), 64'(tbl[i].last));
            chk($sformatf("tbl%0d_tdata_lo", i), m_tdata[63:0], exp_td[63:0]);
            chk($sformatf("tbl%0d_tdata_eq", i), 64'(m_tdata == exp_td), 64'd1);
            chk($sformatf("tbl%0d_tuser_eq", i), 64'(m_tuser == exp_tu), 64'd1);
            chk($sformatf("tbl%0d_tkeep", i), m_tkeep, exp_tk);
            s_tvalid = 1'b0;
            s_tlast  = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_bypass", i), 64'(bypass_mode), 64'(tbl[i].exp_byp));
        end
        chk("tbl_count_kept", 64'(phv_count), 64'(FD + 1));

        // mode switch with three PHVs in flight
        got_q.delete();
        pif.phv_in = 64'h10;
        pif.phv_in_valid = 1'b1;
        @(negedge clk);
        pif.phv_in = 64'h11;
        @(negedge clk);
        pif.phv_in = 64'h12;
        drive_beat(1'b1, 1'b1, hw(1'b1, 1'b0, 4'(SID), 4'hF), 50);
        @(negedge clk);
        pif.phv_in_valid = 1'b0;
        s_tvalid = 1'b0;
        chk("sw_hdr_fwd_valid", 64'(m_tvalid), 64'd1);
        chk("sw_hdr_fwd_data", m_tdata[63:0], {32'hC0DE_0032, hw(1'b1, 1'b0, 4'(SID), 4'hF)});
        viol  = 0;
        waits = 0;
        while (!bypass_mode && waits < 20) begin
            if (pif.stage_ready_out) viol++;
            @(negedge clk);
            waits++;
        end
        chk("sw_ready_held_low", 64'(viol), 64'd0);
        chk("sw_bypass_set", 64'(bypass_mode), 64'd1);
        lat_test(64'h13, 2, "byp");
        repeat (2) @(negedge clk);
        chk("sw_order_n", 64'(got_q.size()), 64'd4);
        for (int i = 0; i < got_q.size(); i++) begin
            chk($sformatf("sw_order%0d", i), 64'(got_q[i]), 64'h10 + 64'(i));
        end

        // back to normal
        send_hdr(1'b0, 1'b0);
        @(negedge clk);
        chk("back_normal", 64'(bypass_mode), 64'd0);

        // counter wrap
        force dut.cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.cnt_q;
        #1;
        chk("wrap_preload", 64'(phv_count), 64'hFFFF_FFFF);
        @(negedge clk);
        lat_test(64'h20, LAT + 1, "wrap");
        @(negedge clk);
        chk("wrap_zero", 64'(phv_count), 64'd0);

        // clear header coinciding with a pop
        lat_test(64'h21, LAT + 1, "clr_a");
        @(negedge clk);
        chk("clr_pre_count", 64'(phv_count), 64'd1);
        pif.stage_ready_in = 1'b0;
        pif.phv_in = 64'h22;
        pif.phv_in_valid = 1'b1;
        @(negedge clk);
        pif.phv_in_valid = 1'b0;
        repeat (LAT + 1) @(negedge clk);
        chk("clr_head_valid", 64'(pif.phv_out_valid), 64'd1);
        pif.stage_ready_in = 1'b1;
        drive_beat(1'b1, 1'b1, hw(1'b0, 1'b1, 4'(SID), 4'hF), 60);
        @(negedge clk);
        s_tvalid = 1'b0;
        chk("clr_with_pop", 64'(phv_count), 64'd0);
        chk("clr_popped", 64'(pif.phv_out_valid), 64'd0);
        @(negedge clk);
        chk("clr_stays", 64'(phv_count), 64'd0);
        chk("clr_mode_kept", 64'(bypass_mode), 64'd0);

        // reset in the middle of traffic and of a control packet
        pif.stage_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pif.phv_in = 64'h40 + 64'(i);
            pif.phv_in_valid = 1'b1;
            @(negedge clk);
        end
        pif.phv_in_valid = 1'b0;
        drive_beat(1'b1, 1'b0, hw(1'b0, 1'b0, 4'(SID + 1), 4'hF), 70);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 64'(pif.phv_out_valid), 64'd0);
        chk("mid_rst_ready", 64'(pif.stage_ready_out), 64'd0);
        chk("mid_rst_m_tvalid", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        chk("mid_rst_valid2", 64'(pif.phv_out_valid), 64'd0);
        chk("mid_rst_m_tvalid2", 64'(m_tvalid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        #1;
        chk("after_rst_ready", 64'(pif.stage_ready_out), 64'd1);
        repeat (LAT + 3) @(negedge clk);
        chk("after_rst_empty", 64'(pif.phv_out_valid), 64'd0);
        chk("after_rst_count", 64'(phv_count), 64'd0);
        send_hdr(1'b1, 1'b0);
        chk("after_rst_hdr", 64'(bypass_mode), 64'd1);
        pif.stage_ready_in = 1'b1;
        lat_test(64'h31, 2, "after_rst_byp");
        @(negedge clk);
        chk("after_rst_pop", 64'(phv_count), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/stage_shell_v2.md
Name: stage_shell_v2

Overview:
- Parametrised successor of the per-stage match-action shell.
- Carries PHVs through a fixed-latency processing slot of LATENCY cycles into an elastic output FIFO, with credit-based backpressure.
- Runtime bypass mode, configured in-band over the daisy-chained control AXIS path, sends PHVs through a single register instead of the LATENCY slot.
- Keeps a per-stage emitted-PHV counter. Sits between consecutive RMT stages in the pipeline.

Parameters:
- C_S_AXIS_DATA_WIDTH, 512, control AXIS data width.
- C_S_AXIS_TUSER_WIDTH, 128, control AXIS tuser width.
- STAGE_ID, 0, 4-bit stage identifier matched against control headers; valid 0-15.
- PHV_LEN, 1024, PHV width in bits.
- LATENCY, 4, processing-slot depth in cycles; legal range 1-16.
- FIFO_DEPTH, 8, output FIFO entries; power of two, must be >= LATENCY+2.

Ports:
- clk  in  1  stage clock.
- rst  in  1  synchronous, active-high reset.
- phv_in  in  PHV_LEN  incoming PHV.
- phv_in_valid  in  1  PHV strobe; accepted only when stage_ready_out=1.
- stage_ready_out  out  1  stage can accept a PHV this cycle.
- phv_out  out  PHV_LEN  FIFO head.
- phv_out_valid  out  1  FIFO non-empty.
- stage_ready_in  in  1  downstream pops the head when high with phv_out_valid.
- c_s_axis_tdata/tuser/tkeep/tvalid/tlast  in  512/128/64/1/1  control input.
- c_m_axis_tdata/tuser/tkeep/tvalid/tlast  out  512/128/64/1/1  control output.
- bypass_mode  out  1  current active mode.
- phv_count  out  32  PHVs popped since reset or clear.

Behaviour:
- Reset (sync, rst=1): FIFO emptied, slot valids cleared, bypass_mode=0, pending cleared, phv_count=0, control FSM=IDLE.
  - During reset: all c_m_axis_* outputs are 0, phv_out_valid=0, stage_ready_out=0.
  - stage_ready_out may rise on the first cycle after rst deasserts.
- Occupancy:
  - occ = fifo_count + number of valid entries in the slot (normal mode) or the bypass register (bypass mode).
  - stage_ready_out = (occ < FIFO_DEPTH) and not rst.
  - Combinational from registered state only, so it is independent of stage_ready_in.
- Data path, normal mode:
  - An accepted PHV enters a LATENCY-deep shift register with valid bits. The slot never stalls.
  - The PHV is written to the FIFO exactly LATENCY cycles after acceptance, and is visible on phv_out the following cycle.
  - Accept-to-phv_out_valid latency: LATENCY+1.
- Data path, bypass mode: one register stage before the FIFO; accept-to-valid latency is 2.
- Credit rule: the credit check guarantees the FIFO never overflows. A write into a full FIFO is a design error; flag it with an assertion.
- FIFO:
  - First-word fall-through.
  - Simultaneous push and pop are allowed at any count, including full and empty; a push and pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- PHV order is always preserved.
- Control FSM (states IDLE, IN_PKT):
  - Every control beat is forwarded unchanged with exactly 1 cycle of latency, whether or not it is consumed.
  - IDLE to IN_PKT on a tvalid beat with tlast=0. IN_PKT to IDLE on a tvalid beat with tlast=1. A tvalid beat with tlast=1 in IDLE stays in IDLE.
  - Only a beat received in IDLE is a header.
- Config header: tdata[15:12]==STAGE_ID and tdata[11:8]==4'hF.
  - tdata[16] = requested bypass value.
  - tdata[17] = counter-clear request.
- Counter clear: phv_count becomes 0 on the cycle after the header. If a pop occurs on the same cycle, the clear wins and the count is 0.
- Mode switch:
  - The requested bypass value is latched into a pending register.
  - bypass_mode takes the pending value only on a cycle where the slot/bypass register holds no valid PHV and no PHV is accepted that cycle.
  - stage_ready_out is forced to 0 while a pending change differs from bypass_mode. This drains the pipeline and prevents reordering.
  - A later header overwrites the pending value; the last write wins.
  - A request equal to the current mode has no stall effect.
- phv_count: increments by 1 on each pop; 32-bit wrap from 0xFFFFFFFF to 0.
- Reset mid-operation: in-flight PHVs and any partial control packet are discarded. The FSM returns to IDLE, so the next beat is treated as a header.

Test Plan:
- Normal flow, LATENCY=4: one PHV=0xA5.. at cycle t with stage_ready_in=1 -> phv_out_valid rises at t+5 with identical data; phv_count=1.
- Backpressure: stage_ready_in=0, stream 20 PHVs with sequence tags -> stage_ready_out drops once occ=8 and exactly 8 PHVs are accepted; release -> tags 0..7 emerge in order, no loss or duplication.
- Bypass config: single-beat header with tdata[15:12]=STAGE_ID, [11:8]=F, [16]=1 -> forwarded unchanged 1 cycle later; bypass_mode=1 after drain; new PHV latency=2.
- Mode switch with 3 PHVs in flight: header requesting bypass -> stage_ready_out=0 until the slot is empty, then bypass_mode=1; output order preserved.
- Foreign header (STAGE_ID+1) and multi-beat packet whose second beat matches the header pattern -> bypass_mode and phv_count unchanged; all beats forwarded.
- Counter: preload to 0xFFFFFFFF via 2^32 pops or a force, pop once -> 0. Clear header coinciding with a pop -> 0. rst asserted mid-stream -> phv_out_valid=0 and stage_ready_out=0 during reset, FIFO empty afterwards.
